alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issue/writeback controller that sits directly upstream of the combinational 8-bit alu (OP[3:0], A, B -> Z). It accepts one instruction at a time over a valid/ready handshake, reads operands from a small internal register file (or an immediate), drives the alu, and captures Z. It then writes Z back to the destination register and presents the result downstream over a second valid/ready handshake.

Parameters:
WIDTH, 8, datapath width; matches the alu A/B/Z width.
NREGS, 4, register file depth; index width RW = clog2(NREGS) = 2.
NUM_OPS, 10, count of legal opcodes (0..NUM_OPS-1); opcodes >= NUM_OPS are illegal.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  instruction offered.
instr_ready  out  1  sequencer can accept an instruction.
instr_op  in  4  alu opcode.
instr_dst  in  RW  destination register.
instr_srca  in  RW  source A register.
instr_srcb  in  RW  source B register.
instr_imm_en  in  1  1: the B operand is instr_imm instead of rf[srcb].
instr_imm  in  WIDTH  immediate value.
alu_op  out  4  to alu OP, registered.
alu_a  out  WIDTH  to alu A, registered.
alu_b  out  WIDTH  to alu B, registered.
alu_z  in  WIDTH  from alu Z.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts the result.
res_data  out  WIDTH  captured result.
res_dst  out  RW  register that was written.
res_err  out  1  the opcode was illegal.

Behaviour:
- Reset (async, rst_n=0) sets every output and state register:
  - State = IDLE, instr_ready=1, res_valid=0, res_err=0.
  - alu_op=0, alu_a=0, alu_b=0, res_data=0, res_dst=0.
  - All rf entries = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - instr_ready=1.
  - On a clock edge with instr_valid=1:
    - alu_op <= instr_op.
    - alu_a <= rf[srca].
    - alu_b <= imm_en ? imm : rf[srcb].
    - Latch dst.
    - instr_ready <= 0, go to EXEC.
  - With instr_valid=0: stay in IDLE, all outputs hold.
- EXEC (exactly 1 cycle):
  - alu_z is sampled on the edge ending EXEC.
  - Legal opcode (< NUM_OPS): rf[dst] <= alu_z, res_data <= alu_z, res_err <= 0.
  - Illegal opcode: rf is unchanged, res_data <= 0, res_err <= 1.
  - In both cases: res_dst <= dst, res_valid <= 1, go to RESP.
- RESP:
  - res_valid, res_data, res_dst and res_err hold stable until res_ready=1.
  - On the edge with res_ready=1: res_valid <= 0, instr_ready <= 1, go to IDLE.
- Latency: accept edge -> res_valid=1 is 2 edges. Minimum issue interval is 3 cycles (res_ready tied 1).
- alu_op, alu_a and alu_b hold their last values outside EXEC.
- instr_* inputs are ignored whenever instr_ready=0.
- No bypass is required. Writeback completes before the next accept, so a dependent instruction always reads the updated register.
- dst == srca or dst == srcb is legal; the operands are captured at accept, before writeback.
- Reset mid-operation (EXEC or RESP): the in-flight instruction is abandoned, no writeback occurs, and the FSM returns to IDLE with all reset values.
- instr_valid asserted in the same cycle as the res_ready handshake: not accepted until the following IDLE cycle; no combinational ready path.

Test Plan:
- Reset, then zero/one/load:
  - Reset, then check every output equals its reset value and instr_ready=1.
  - op=1, dst=r0 -> res_data=0x01, res_err=0, res_valid 2 edges after accept.
  - op=0, dst=r1 -> res_data=0x00.
  - imm=0xAA, op=3 (B), imm_en, dst=r1 -> res_data=0xAA, r1=0xAA.
- Arithmetic: r1=0xAA, r2=0x0F (loaded via op=3 imm).
  - op=4 r1+r2 -> 0xB9.
  - op=5 on r1 -> 0x56.
  - op=2 with srca=r1 -> 0xAA.
- Logic/compare: r1=0x55, imm=0xF0.
  - op=6 -> 0x50.
  - op=7 -> 0xF5.
  - r2=0x0F, op=8 (r2 == imm 0x0F) -> 0x01.
  - op=9 with 0x0F > 0x00 -> 0x01.
  - op=9 with 0x00 > 0x0F -> 0x00.
- Backpressure:
  - Hold res_ready=0 for 5 cycles -> res_valid stays 1, res_data stable, instr_ready=0, and a new instr_valid is ignored.
  - Release res_ready -> res_valid drops and instr_ready=1 on the next cycle.
- Illegal opcode: op=12, dst=r3 (r3=0x77) -> res_err=1, res_data=0x00, r3 still 0x77 (confirm with op=2 srca=r3 -> 0x77).
- Async reset in EXEC:
  - Pulse rst_n low mid-cycle -> outputs go to reset values immediately (no clock edge), no writeback.
  - After release, op=2 srca=dst reads 0x00.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue controller that reads a small register file, drives an
// external combinational alu, writes the result back and hands it downstream.
module alu_sequencer #(
   parameter  int WIDTH   = 8,
   parameter  int NREGS   = 4,
   parameter  int NUM_OPS = 10,
   localparam int RW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_op,
   input  logic [RW-1:0]    instr_dst,
   input  logic [RW-1:0]    instr_srca,
   input  logic [RW-1:0]    instr_srcb,
   input  logic             instr_imm_en,
   input  logic [WIDTH-1:0] instr_imm,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_z,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [RW-1:0]    res_dst,
   output logic             res_err
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           r_state;
   logic [RW-1:0]    r_dst;
   logic [WIDTH-1:0] r_rf [NREGS];
   logic             w_legal;

   assign w_legal = int'(alu_op) < NUM_OPS;

   // Operands are captured at accept, so dst may alias a source without hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_dst       <= '0;
         instr_ready <= 1'b1;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_dst     <= '0;
         res_err     <= 1'b0;
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      end else begin
         case (r_state)
            IDLE: if (instr_valid) begin
               alu_op      <= instr_op;
               alu_a       <= r_rf[instr_srca];
               alu_b       <= instr_imm_en ? instr_imm : r_rf[instr_srcb];
               r_dst       <= instr_dst;
               instr_ready <= 1'b0;
               r_state     <= EXEC;
            end
            EXEC: begin
               if (w_legal) r_rf[r_dst] <= alu_z;
               res_data  <= w_legal ? alu_z : '0;
               res_err   <= !w_legal;
               res_dst   <= r_dst;
               res_valid <= 1'b1;
               r_state   <= RESP;
            end
            RESP: if (res_ready) begin
               res_valid   <= 1'b0;
               instr_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with a behavioural alu model closing the loop
// around alu_sequencer; expected results are hand-computed constants.
module tb_alu_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_op = '0;
   logic [1:0] instr_dst = '0;
   logic [1:0] instr_srca = '0;
   logic [1:0] instr_srcb = '0;
   logic       instr_imm_en = 1'b0;
   logic [7:0] instr_imm = '0;
   logic [3:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_z;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic [1:0] res_dst;
   logic       res_err;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_dst(instr_dst),
      .instr_srca(instr_srca), .instr_srcb(instr_srcb),
      .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_dst(res_dst), .res_err(res_err)
   );

   // Illegal opcodes return a non-zero pattern so a forced-zero result is observable.
   always_comb begin
      alu_z = 8'hEE;
      case (alu_op)
         4'd0: alu_z = 8'h00;
         4'd1: alu_z = 8'h01;
         4'd2: alu_z = alu_a;
         4'd3: alu_z = alu_b;
         4'd4: alu_z = alu_a + alu_b;
         4'd5: alu_z = 8'h00 - alu_a;
         4'd6: alu_z = alu_a & alu_b;
         4'd7: alu_z = alu_a | alu_b;
         4'd8: alu_z = {7'd0, alu_a == alu_b};
         4'd9: alu_z = {7'd0, alu_a > alu_b};
         default: alu_z = 8'hEE;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start(input string tag, input logic [3:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [1:0] sb, input logic ie,
                        input logic [7:0] imm, input logic [7:0] ed, input logic ee);
      @(negedge clk);
      chk({tag, ".rdy"}, 32'(instr_ready), 1);
      instr_valid = 1'b1; instr_op = op; instr_dst = dst;
      instr_srca = sa; instr_srcb = sb; instr_imm_en = ie; instr_imm = imm;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk({tag, ".exec_vld"}, 32'(res_valid), 0);
      chk({tag, ".exec_rdy"}, 32'(instr_ready), 0);
      @(posedge clk); #1;
      chk({tag, ".vld"}, 32'(res_valid), 1);
      chk({tag, ".data"}, 32'(res_data), 32'(ed));
      chk({tag, ".err"}, 32'(res_err), 32'(ee));
      chk({tag, ".dst"}, 32'(res_dst), 32'(dst));
   endtask

   task automatic finish_resp(input string tag);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk({tag, ".done_vld"}, 32'(res_valid), 0);
      chk({tag, ".done_rdy"}, 32'(instr_ready), 1);
   endtask

   task automatic run(input string tag, input logic [3:0] op, input logic [1:0] dst,
                      input logic [1:0] sa, input logic [1:0] sb, input logic ie,
                      input logic [7:0] imm, input logic [7:0] ed, input logic ee);
      start(tag, op, dst, sa, sb, ie, imm, ed, ee);
      finish_resp(tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.rdy", 32'(instr_ready), 1);
      chk("rst.vld", 32'(res_valid), 0);
      chk("rst.err", 32'(res_err), 0);
      chk("rst.op", 32'(alu_op), 0);
      chk("rst.a", 32'(alu_a), 0);
      chk("rst.b", 32'(alu_b), 0);
      chk("rst.data", 32'(res_data), 0);
      chk("rst.dst", 32'(res_dst), 0);
      @(negedge clk); rst_n = 1'b1;

      run("one",  4'd1, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h01, 1'b0);
      run("zero", 4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      run("ldr1", 4'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'hAA, 8'hAA, 1'b0);
      run("ldr2", 4'd3, 2'd2, 2'd0, 2'd0, 1'b1, 8'h0F, 8'h0F, 1'b0);
      run("add",  4'd4, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'hB9, 1'b0);
      run("neg",  4'd5, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'h56, 1'b0);
      run("pass", 4'd2, 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'hAA, 1'b0);

      run("ld55", 4'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55, 8'h55, 1'b0);
      run("and",  4'd6, 2'd3, 2'd1, 2'd0, 1'b1, 8'hF0, 8'h50, 1'b0);
      run("or",   4'd7, 2'd3, 2'd1, 2'd0, 1'b1, 8'hF0, 8'hF5, 1'b0);
      run("eq",   4'd8, 2'd3, 2'd2, 2'd0, 1'b1, 8'h0F, 8'h01, 1'b0);
      run("gt1",  4'd9, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 8'h01, 1'b0);
      run("clr0", 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      run("gt0",  4'd9, 2'd3, 2'd0, 2'd2, 1'b0, 8'h00, 8'h00, 1'b0);

      start("bp", 4'd2, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'h55, 1'b0);
      @(negedge clk);
      instr_valid = 1'b1; instr_op = 4'd4; instr_dst = 2'd0;
      instr_srca = 2'd1; instr_srcb = 2'd2; instr_imm_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.vld", 32'(res_valid), 1);
         chk("bp.data", 32'(res_data), 32'h55);
         chk("bp.rdy", 32'(instr_ready), 0);
         chk("bp.op", 32'(alu_op), 2);
      end
      finish_resp("bp");
      chk("bp.noacc_op", 32'(alu_op), 2);
      @(negedge clk); instr_valid = 1'b0;
      run("r0chk", 4'd2, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);

      run("ld77", 4'd3, 2'd3, 2'd0, 2'd0, 1'b1, 8'h77, 8'h77, 1'b0);
      run("ill",  4'd12, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h00, 1'b1);
      run("r3",   4'd2, 2'd1, 2'd3, 2'd0, 1'b0, 8'h00, 8'h77, 1'b0);

      @(negedge clk);
      instr_valid = 1'b1; instr_op = 4'd3; instr_dst = 2'd2;
      instr_srca = 2'd0; instr_srcb = 2'd0; instr_imm_en = 1'b1; instr_imm = 8'h5A;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("ar.exec_op", 32'(alu_op), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.rdy", 32'(instr_ready), 1);
      chk("ar.vld", 32'(res_valid), 0);
      chk("ar.op", 32'(alu_op), 0);
      chk("ar.b", 32'(alu_b), 0);
      chk("ar.data", 32'(res_data), 0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      run("ar.r2", 4'd2, 2'd2, 2'd2, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);
      run("ar.r1", 4'd2, 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
